// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: receive-side handshake between the UART receiver and the
// register/FIFO layer. The receiver drives the word, its valid flag and the
// per-frame error pulses; the consumer drives rx_ready.
interface uart_rx_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output parity_err,
      output overrun,
      input  rx_ready
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  parity_err,
      input  overrun,
      output rx_ready
   );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver.
// The rx line is synchronised, the start bit is validated at its centre, and
// every later bit is sampled one full bit period (OVERSAMPLE baud ticks) apart.
// Words are presented on a valid/ready handshake; frame, parity and overrun
// conditions are reported as single-clock pulses.
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the data
// bits, checked for even (PARITY_ODD=0) or odd (PARITY_ODD=1) parity. Without
// it the frame is start + data + stop(s) and parity_err stays low.
module uart_rx_core #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           rx,
   input  logic           baud_tick,
   uart_rx_core_if.master bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic [0:0]    LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } state_t;

   state_t               state;
   state_t               state_n;
   logic                 rx_meta;
   logic                 rx_s;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [0:0]           stop_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 mid_hit;
   logic                 bit_hit;
   logic                 sample_data;
   logic                 frame_ok;
   logic                 frame_bad;
`ifdef UART_RX_PARITY_EN
   logic                 sample_par;
   logic                 parity_bad;
`endif

   assign mid_hit = baud_tick && (tick_cnt == HALF_LAST);
   assign bit_hit = baud_tick && (tick_cnt == FULL_LAST);

   // Two-flop synchroniser; resets to the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state decode and per-tick sampling strobes; nothing moves without a baud tick.
   always_comb begin
      state_n     = state;
      sample_data = 1'b0;
      frame_ok    = 1'b0;
      frame_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
      sample_par  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (baud_tick && !rx_s) begin
               state_n = START;
            end
         end
         START: begin
            if (mid_hit) begin
               state_n = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_hit) begin
               sample_data = 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_hit) begin
               sample_par = 1'b1;
               state_n    = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_hit) begin
               if (!rx_s) begin
                  frame_bad = 1'b1;
                  state_n   = BREAK;
               end else if (stop_cnt == LAST_STOP) begin
                  frame_ok = 1'b1;
                  state_n  = IDLE;
               end
            end
         end
         BREAK: begin
            if (baud_tick && rx_s) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Tick/bit/stop counters and the data shift register, advanced only on baud ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= '0;
         shift_reg  <= '0;
`ifdef UART_RX_PARITY_EN
         parity_bad <= 1'b0;
`endif
      end else if (baud_tick) begin
         if ((state_n != state) || bit_hit || (state == IDLE) || (state == BREAK)) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + TW'(1);
         end
         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (sample_data) begin
            bit_cnt <= bit_cnt + BW'(1);
         end
         if (state != STOP) begin
            stop_cnt <= '0;
         end else if (bit_hit) begin
            stop_cnt <= stop_cnt + 1'b1;
         end
         if (sample_data) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
         end
`ifdef UART_RX_PARITY_EN
         if (state == START) begin
            parity_bad <= 1'b0;
         end else if (sample_par) begin
            parity_bad <= ((^shift_reg) ^ rx_s) != PAR_ODD;
         end
`endif
      end
   end

   // Word delivery, handshake and error pulses; a completing frame may replace a word accepted on the same clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rx_data    <= '0;
         bus.rx_valid   <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.frame_err <= frame_bad;
         bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         bus.parity_err <= frame_ok && parity_bad;
`else
         bus.parity_err <= 1'b0 & PAR_ODD;
`endif
         if (frame_ok) begin
            if (!bus.rx_valid || bus.rx_ready) begin
               bus.rx_data  <= shift_reg;
               bus.rx_valid <= 1'b1;
            end else begin
               bus.overrun <= 1'b1;
            end
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

endmodule
